freq_period_meter: RTL and testbench

- Measures a slow square wave against the 50 MHz system clock. This is the inverse of the slow-clock divider.
- Typical inputs are a divided clock, an external test signal or a board pin.
- Reports period and high time in CLOCK_50 cycles, with a one-cycle valid strobe and a timeout flag.
- Sits beside the clock divider so the divider's output, or any board input, can be checked on-chip.

---
 rtl/freq_meter_pkg.sv | 18 +
 rtl/freq_period_meter_sig_sync_edge.sv | 35 +++
 rtl/freq_period_meter.sv | 189 ++++++++++++++++++
 tb/tb_freq_period_meter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_meter_pkg.sv
// Shared state type and constants for the frequency / period meter.
package freq_meter_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        MEASURE = 2'd1,
        STALL   = 2'd2
    } meter_state_e;

    localparam int CNT_W_DEF = 32;

    // Stall timeouts in CLOCK_50 cycles
    localparam int unsigned TIMEOUT_1S  = 32'd50000000;
    localparam int unsigned TIMEOUT_2S  = 32'd100000000;
    localparam int unsigned TIMEOUT_5S  = 32'd250000000;
    localparam int unsigned TIMEOUT_10S = 32'd500000000;

endpackage

// File: rtl/freq_period_meter_sig_sync_edge.sv
// Multi-flop synchronizer for the measured input plus a history flop for edge detection.
// Rise and fall come from the same pair of flops, so both edges see identical latency.
module sig_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sig_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("sig_sync_edge: SYNC_STAGES must be at least 2");
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], sig_i};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;
    assign fall_o = ~sync_q[SYNC_STAGES-1] & hist_q;

endmodule

// File: rtl/freq_period_meter.sv
// Period / high-time meter for a slow square wave, counted in CLOCK_50 cycles.
// Define FREQ_METER_AVG_EN to add a four-sample running period average.
//
//   state   | meaning
//   IDLE    | waiting for the first rising edge; counter parked at 0
//   MEASURE | counting cycles since the last rising edge
//   STALL   | no rising edge for TIMEOUT cycles; timeout flag raised
module freq_period_meter
    import freq_meter_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEF,
    parameter int unsigned TIMEOUT     = TIMEOUT_10S,
    parameter int          SYNC_STAGES = 2
) (
    input  logic             CLOCK_50,
    input  logic             reset,
    input  logic             sig_in,
    input  logic             clear,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             meas_valid,
    output logic             timeout,
    output logic             busy
`ifdef FREQ_METER_AVG_EN
    ,
    output logic [CNT_W-1:0] period_avg,
    output logic             avg_valid
`endif
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TC  = CNT_W'(TIMEOUT - 1);

    if (TIMEOUT == 0) begin : g_bad_timeout
        $error("freq_period_meter: TIMEOUT must be non-zero");
    end
    if (CNT_W < 33 && 64'(TIMEOUT) >= (64'd1 << CNT_W)) begin : g_bad_width
        $error("freq_period_meter: TIMEOUT does not fit in CNT_W bits");
    end

    logic sync, rise, fall;

    sig_sync_edge #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk_i (CLOCK_50),
        .rst_ni(reset),
        .sig_i (sig_in),
        .sync_o(sync),
        .rise_o(rise),
        .fall_o(fall)
    );

    meter_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic [CNT_W-1:0] high_pend_q, high_pend_d;
    logic             valid_q, valid_d;
    logic             low_seen_q, low_seen_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_ONE;

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            period_q    <= '0;
            high_q      <= '0;
            high_pend_q <= '0;
            valid_q     <= 1'b0;
            low_seen_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            period_q    <= period_d;
            high_q      <= high_d;
            high_pend_q <= high_pend_d;
            valid_q     <= valid_d;
            low_seen_q  <= low_seen_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        period_d    = period_q;
        high_d      = high_q;
        high_pend_d = high_pend_q;
        valid_d     = 1'b0;
        low_seen_d  = low_seen_q;

        if (clear) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (rise) begin
                        state_d    = MEASURE;
                        low_seen_d = 1'b0;
                    end
                end
                MEASURE: begin
                    cnt_d = cnt_inc;
                    if (!sync) low_seen_d = 1'b1;
                    if (fall) high_pend_d = cnt_inc;
                    // With no low phase seen the input stayed high the whole period
                    if (rise) begin
                        period_d   = cnt_inc;
                        high_d     = low_seen_q ? high_pend_q : cnt_inc;
                        valid_d    = 1'b1;
                        cnt_d      = '0;
                        low_seen_d = 1'b0;
                    end else if (cnt_q == CNT_TC) begin
                        state_d = STALL;
                        cnt_d   = cnt_q;
                    end
                end
                STALL: begin
                    if (rise) begin
                        state_d    = MEASURE;
                        cnt_d      = '0;
                        low_seen_d = 1'b0;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign period_out = period_q;
    assign high_out   = high_q;
    assign meas_valid = valid_q;
    assign timeout    = (state_q == STALL);
    assign busy       = (state_q == MEASURE);

`ifdef FREQ_METER_AVG_EN
    logic [3:0][CNT_W-1:0] buf_q, buf_d;
    logic [2:0]            fill_q, fill_d;
    logic [CNT_W-1:0]      avg_q, avg_d;
    logic                  avg_valid_q, avg_valid_d;
    logic [CNT_W+1:0]      sum;

    assign sum = {2'b00, cnt_inc} + {2'b00, buf_q[0]} + {2'b00, buf_q[1]} + {2'b00, buf_q[2]};

    always_ff @(posedge CLOCK_50) begin
        if (!reset) begin
            buf_q       <= '0;
            fill_q      <= '0;
            avg_q       <= '0;
            avg_valid_q <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            fill_q      <= fill_d;
            avg_q       <= avg_d;
            avg_valid_q <= avg_valid_d;
        end
    end

    // buf_q[0] holds the newest period; the average includes the one being published
    always_comb begin
        buf_d       = buf_q;
        fill_d      = fill_q;
        avg_d       = avg_q;
        avg_valid_d = 1'b0;
        if (clear) begin
            buf_d  = '0;
            fill_d = '0;
        end else if (valid_d) begin
            buf_d  = {buf_q[2:0], cnt_inc};
            fill_d = (fill_q == 3'd4) ? fill_q : fill_q + 3'd1;
            if (fill_q >= 3'd3) begin
                avg_d       = sum[CNT_W+1:2];
                avg_valid_d = 1'b1;
            end
        end
    end

    assign period_avg = avg_q;
    assign avg_valid  = avg_valid_q;
`endif

endmodule

// File: tb/tb_freq_period_meter.sv
// Self-checking bench for freq_period_meter: directed and random square waves
// compared each cycle against a pin-level model of edge times and published intervals.
module tb_freq_period_meter;

    localparam int CW  = 32;
    localparam int TO  = 100;
    localparam int SS  = 2;
    localparam int LAT = SS + 1;  // pin drive (negedge) to the cycle the FSM result is visible

    logic          clk = 1'b0;
    logic          rst_n, sig, clr;
    logic [CW-1:0] per, hi;
    logic          mv, to, bsy;
`ifdef FREQ_METER_AVG_EN
    logic [CW-1:0] pavg;
    logic          av;
`endif

    freq_period_meter #(
        .CNT_W      (CW),
        .TIMEOUT    (TO),
        .SYNC_STAGES(SS)
    ) dut (
        .CLOCK_50  (clk),
        .reset     (rst_n),
        .sig_in    (sig),
        .clear     (clr),
        .period_out(per),
        .high_out  (hi),
        .meas_valid(mv),
        .timeout   (to),
        .busy      (bsy)
`ifdef FREQ_METER_AVG_EN
        ,
        .period_avg(pavg),
        .avg_valid (av)
`endif
    );

    always #10 clk = ~clk;

    typedef struct {
        int due;
        int p;
        int h;
    } pub_t;

    int   errors = 0;
    int   checks = 0;
    int   cyc = 0;
    int   n_valid = 0;
    int   last_rise = -1;
    int   last_fall = -1;
    int   acted = -1;
    int   ctrl_at = 1;
    bit   ctrl_rst = 1'b1;
    int   exp_per = 0;
    int   exp_hi = 0;
    bit   prev_sig = 1'b0;
    int   rise_q[$];
    pub_t pub_q[$];
    int   avg_hist[$];
    int   avg_fill = 0;
    int   exp_avg = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0d expected=%0d", tag, cyc, obs, exp);
        end
    endtask

    // One cycle: update the model, compare all outputs, then drive the next inputs.
    task automatic step(input logic s, input logic c, input logic r);
        pub_t p;
        bit   ev;
        bit   ex_to;
        bit   ex_av;
        int   sum;
        @(negedge clk);
        cyc++;
        if (ctrl_at == cyc) begin
            last_rise = -1;
            acted     = -1;
            rise_q.delete();
            pub_q.delete();
            avg_hist.delete();
            avg_fill = 0;
            if (ctrl_rst) begin
                exp_per = 0;
                exp_hi  = 0;
                exp_avg = 0;
            end
        end
        while (rise_q.size() > 0 && rise_q[0] + LAT == cyc) acted = rise_q.pop_front();
        ev    = 1'b0;
        ex_av = 1'b0;
        if (pub_q.size() > 0 && pub_q[0].due == cyc) begin
            p       = pub_q.pop_front();
            ev      = 1'b1;
            exp_per = p.p;
            exp_hi  = p.h;
            avg_hist.push_back(p.p);
            if (avg_hist.size() > 4) void'(avg_hist.pop_front());
            if (avg_fill < 4) avg_fill++;
            if (avg_fill >= 4) begin
                sum = 0;
                foreach (avg_hist[i]) sum += avg_hist[i];
                exp_avg = sum / 4;
                ex_av   = 1'b1;
            end
        end
        ex_to = (acted >= 0) && (cyc - acted >= TO + LAT);
        chk("meas_valid", 64'(mv), 64'(ev));
        chk("period_out", 64'(per), 64'(exp_per));
        chk("high_out", 64'(hi), 64'(exp_hi));
        chk("timeout", 64'(to), 64'(ex_to));
        chk("busy", 64'(bsy), 64'((acted >= 0) && !ex_to));
`ifdef FREQ_METER_AVG_EN
        chk("avg_valid", 64'(av), 64'(ex_av));
        chk("period_avg", 64'(pavg), 64'(exp_avg));
`endif
        if (mv === 1'b1) n_valid++;

        if (s && !prev_sig) begin
            if (last_rise >= 0 && cyc - last_rise <= TO)
                pub_q.push_back('{cyc + LAT, cyc - last_rise, last_fall - last_rise});
            last_rise = cyc;
            rise_q.push_back(cyc);
        end
        if (!s && prev_sig) last_fall = cyc;
        prev_sig = s;
        sig      = s;
        clr      = c;
        rst_n    = ~r;
        if (c || r) begin
            ctrl_at  = cyc + 1;
            ctrl_rst = r;
        end
    endtask

    task automatic hold(input logic s, input int n);
        for (int i = 0; i < n; i++) step(s, 1'b0, 1'b0);
    endtask

    task automatic wave(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            hold(1'b1, h);
            hold(1'b0, l);
        end
    endtask

    int nv0;
    int h, l;

    initial begin
        rst_n = 1'b0;
        sig   = 1'b0;
        clr   = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b1);
        hold(1'b0, 6);

        // 10-cycle period, 4 high: five measurements from six rises
        wave(4, 6, 6);
        hold(1'b0, 5);
        chk("p10_count", 64'(n_valid), 64'd5);
        chk("p10_period", 64'(per), 64'd10);
        chk("p10_high", 64'(hi), 64'd4);

        // divider-style 50% duty, 50-cycle period
        wave(25, 25, 4);
        hold(1'b1, 5);
        chk("p50_period", 64'(per), 64'd50);
        chk("p50_high", 64'(hi), 64'd25);
        chk("p50_timeout", 64'(to), 64'd0);

        // input stops low: stall, outputs hold, then recovery
        hold(1'b0, 120);
        chk("stall_flag", 64'(to), 64'd1);
        chk("stall_hold", 64'(per), 64'd50);
        wave(7, 8, 3);
        hold(1'b0, 5);
        chk("recover_timeout", 64'(to), 64'd0);
        chk("recover_period", 64'(per), 64'd15);
        chk("recover_high", 64'(hi), 64'd7);

        // period exactly TIMEOUT is published, TIMEOUT+1 is not
        wave(40, 60, 2);
        hold(1'b1, 10);
        chk("tc_period", 64'(per), 64'd100);
        chk("tc_high", 64'(hi), 64'd40);
        chk("tc_timeout", 64'(to), 64'd0);
        hold(1'b0, 91);
        hold(1'b1, 10);
        chk("tc1_hold", 64'(per), 64'd100);
        hold(1'b0, 10);

        // clear mid-period discards the interval
        wave(10, 10, 3);
        hold(1'b1, 5);
        step(1'b1, 1'b1, 1'b0);
        hold(1'b1, 4);
        hold(1'b0, 10);
        nv0 = n_valid;
        wave(10, 10, 1);
        chk("clr_novalid", 64'(n_valid), 64'(nv0));
        hold(1'b1, 5);
        chk("clr_valid", 64'(n_valid), 64'(nv0 + 1));
        chk("clr_period", 64'(per), 64'd20);
        chk("clr_high", 64'(hi), 64'd10);

        // reset mid-period zeroes the outputs
        hold(1'b0, 5);
        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        hold(1'b0, 5);
        chk("rst_period", 64'(per), 64'd0);
        chk("rst_high", 64'(hi), 64'd0);
        chk("rst_busy", 64'(bsy), 64'd0);
        wave(6, 14, 3);
        hold(1'b0, 5);
        chk("rst_after", 64'(per), 64'd20);

        // average over periods 8, 12, 10, 14 after a clear
        hold(1'b0, 8);
        step(1'b0, 1'b1, 1'b0);
        hold(1'b0, 4);
        wave(4, 4, 1);
        wave(6, 6, 1);
        wave(5, 5, 1);
        wave(7, 7, 1);
        hold(1'b1, 5);
        chk("avgseq_period", 64'(per), 64'd14);
`ifdef FREQ_METER_AVG_EN
        chk("avgseq_avg", 64'(pavg), 64'd11);
`endif
        hold(1'b0, 10);

        // random periods, some beyond TIMEOUT, occasional clear
        for (int i = 0; i < 25; i++) begin
            h = $urandom_range(30, 1);
            l = ($urandom_range(7, 0) == 0) ? $urandom_range(110, 95) : $urandom_range(30, 1);
            if (i % 5 == 4 && h >= 8) begin
                hold(1'b1, 5);
                step(1'b1, 1'b1, 1'b0);
                hold(1'b1, h - 6);
            end else begin
                hold(1'b1, h);
            end
            hold(1'b0, l);
        end
        hold(1'b0, 10);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
